// File: rtl/cpu_pkg.sv
// Shared pipeline constants, opcode classification helpers and the memory-stage FSM encoding.
package cpu_pkg;

  localparam logic [6:0]  OPCODE_NOP = 7'b0100000;
  localparam logic [31:0] INSTR_NOP  = 32'hE320F000;

  // Base-register writeback select driven into the execute stage.
  localparam logic [1:0] SEL_W_ALU  = 2'b00;
  localparam logic [1:0] SEL_W_RD   = 2'b01;
  localparam logic [1:0] SEL_W_BASE = 2'b10;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_WAIT_ACK = 1'b1
  } mem_state_t;

  function automatic logic is_load(input logic [6:0] op);
    logic r;
    r = 1'b0;
    casez (op)
      7'b110????: r = 1'b1;
      7'b1000???: r = 1'b1;
      default:    r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_store(input logic [6:0] op);
    logic r;
    r = 1'b0;
    casez (op)
      7'b111????: r = 1'b1;
      default:    r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_memop(input logic [6:0] op);
    return is_load(op) | is_store(op);
  endfunction

  // NOP sits in the data-processing opcode range, so it must be tested first.
  function automatic logic [1:0] sel_w_addr1_of(input logic [6:0] op,
                                                input logic       p_bit,
                                                input logic       w_bit);
    logic [1:0] r;
    r = SEL_W_RD;
    if (is_memop(op) && (!p_bit || w_bit)) r = SEL_W_BASE;
    else if (op == OPCODE_NOP)              r = SEL_W_RD;
    else if (!op[6])                        r = SEL_W_ALU;
    else                                    r = SEL_W_RD;
    return r;
  endfunction

endpackage

// File: rtl/memory_slot_reg.sv
// One pipeline slot {instr, opcode, pc}; loads on enable, loads NOP on reset or enabled flush.
module memory_slot_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [6:0]  opcode_i,
  input  logic [6:0]  pc_i,
  output logic [31:0] instr_o,
  output logic [6:0]  opcode_o,
  output logic [6:0]  pc_o
);

  logic [31:0] instr_q;
  logic [6:0]  opcode_q;
  logic [6:0]  pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q  <= INSTR_NOP;
      opcode_q <= OPCODE_NOP;
      pc_q     <= 7'd0;
    end else if (en_i) begin
      if (flush_i) begin
        instr_q  <= INSTR_NOP;
        opcode_q <= OPCODE_NOP;
        pc_q     <= 7'd0;
      end else begin
        instr_q  <= instr_i;
        opcode_q <= opcode_i;
        pc_q     <= pc_i;
      end
    end
  end

  assign instr_o  = instr_q;
  assign opcode_o = opcode_q;
  assign pc_o     = pc_q;

endmodule

// File: rtl/memory_unit.sv
// Memory-stage controller: M and W slots, data-memory request handshake and upstream stall.
// state    | meaning
// RUN      | slots advance each cycle unless a memop in M misses its ack
// WAIT_ACK | memop outstanding; M held, upstream stalled until mem_ack
module memory_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_in,
  input  logic [6:0]  opcode_in,
  input  logic [6:0]  pc_in,
  input  logic        flush,
  input  logic        mem_ack,
  output logic [3:0]  rn_memory,
  output logic [3:0]  rd_memory,
  output logic [6:0]  opcode_memory,
  output logic [1:0]  sel_w_addr1_memory,
  output logic [3:0]  rt_memory_wait,
  output logic [6:0]  opcode_memory_wait,
  output logic        mem_req,
  output logic        mem_we,
  output logic        sel_mem_addr,
  output logic        stall_mem,
  output logic [31:0] instr_output,
  output logic [6:0]  pc_out
);

  mem_state_t  state_q, state_d;
  logic        advance;
  logic [31:0] instr_m;
  logic [6:0]  opcode_m;
  logic [6:0]  pc_m;
  logic [31:0] instr_w;
  logic [6:0]  opcode_w;
  logic        m_memop;
  logic        m_store;
  logic        m_is_nop;
  logic        w_is_nop;

  memory_slot_reg u_slot_m (
    .clk      (clk),
    .rst      (rst),
    .en_i     (advance),
    .flush_i  (flush),
    .instr_i  (instr_in),
    .opcode_i (opcode_in),
    .pc_i     (pc_in),
    .instr_o  (instr_m),
    .opcode_o (opcode_m),
    .pc_o     (pc_m)
  );

  // A NOP leaving M is normalised so W never carries a stale PC.
  memory_slot_reg u_slot_w (
    .clk      (clk),
    .rst      (rst),
    .en_i     (advance),
    .flush_i  (m_is_nop),
    .instr_i  (instr_m),
    .opcode_i (opcode_m),
    .pc_i     (pc_m),
    .instr_o  (instr_w),
    .opcode_o (opcode_w),
    .pc_o     (pc_out)
  );

  assign m_memop  = is_memop(opcode_m);
  assign m_store  = is_store(opcode_m);
  assign m_is_nop = (opcode_m == OPCODE_NOP);
  assign w_is_nop = (opcode_w == OPCODE_NOP);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    advance   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    stall_mem = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_RUN: begin
          if (m_memop) begin
            mem_req = 1'b1;
            mem_we  = m_store;
            if (mem_ack) begin
              advance = 1'b1;
            end else begin
              stall_mem = 1'b1;
              state_d   = ST_WAIT_ACK;
            end
          end else begin
            advance = 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          mem_req = 1'b1;
          mem_we  = m_store;
          if (mem_ack) begin
            advance = 1'b1;
            state_d = ST_RUN;
          end else begin
            stall_mem = 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // NOP carries no register operands, so its forwarding fields read as zero.
  assign rn_memory          = m_is_nop ? 4'd0 : instr_m[19:16];
  assign rd_memory          = m_is_nop ? 4'd0 : instr_m[15:12];
  assign opcode_memory      = opcode_m;
  assign sel_w_addr1_memory = sel_w_addr1_of(opcode_m, instr_m[24], instr_m[21]);
  assign sel_mem_addr       = m_memop & ~instr_m[24];
  assign rt_memory_wait     = w_is_nop ? 4'd0 : instr_w[15:12];
  assign opcode_memory_wait = opcode_w;
  assign instr_output       = instr_w;

endmodule
